// File: rtl/ddr_pkg.sv
// Shared DDR receive definitions: deserializer mode codes, sequencer state
// encoding and error codes, plus small decode helpers.
package ddr_pkg;

    // Deserializer mode select codes
    localparam logic [3:0] PREAMBLE           = 4'b0000;
    localparam logic [3:0] DESERIALIZING_BYTE = 4'b0011;
    localparam logic [3:0] CHECK_TOKEN        = 4'b0101;
    localparam logic [3:0] CHECK_PAR_VALUE    = 4'b0110;
    localparam logic [3:0] CHECK_CRC_VALUE    = 4'b0111;
    localparam logic [3:0] RX_IDLE            = 4'b1111;

    // Sequencer states
    typedef enum logic [3:0] {
        S_IDLE, S_PRE, S_BYTE0, S_BYTE1, S_PAR, S_TOKEN, S_CRC, S_DONE, S_ERR
    } rx_seq_state_e;

    // Error codes reported on o_err_code
    localparam logic [1:0] ERR_PARITY    = 2'b00;
    localparam logic [1:0] ERR_TOKEN_CRC = 2'b01;
    localparam logic [1:0] ERR_OVERFLOW  = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT   = 2'b11;

    // Deserializer mode driven while in a given state
    function automatic logic [3:0] rx_mode_of(input rx_seq_state_e s);
        case (s)
            S_PRE:            return PREAMBLE;
            S_BYTE0, S_BYTE1: return DESERIALIZING_BYTE;
            S_PAR:            return CHECK_PAR_VALUE;
            S_TOKEN:          return CHECK_TOKEN;
            S_CRC:            return CHECK_CRC_VALUE;
            default:          return RX_IDLE;
        endcase
    endfunction

    // States in which the deserializer is running
    function automatic logic rx_active(input rx_seq_state_e s);
        return s inside {S_PRE, S_BYTE0, S_BYTE1, S_PAR, S_TOKEN, S_CRC};
    endfunction

endpackage

// File: rtl/ddr_rx_sequencer_if.sv
// Control/status bundle between the DDR CCC controller + deserializer and
// the receive sequencer. The slave side is the sequencer.
interface ddr_rx_sequencer_if #(parameter int CNT_W = 5);
    logic             i_start;
    logic             i_abort;
    logic             i_rx_mode_done;
    logic             i_rx_pre;
    logic             i_rx_error;
    logic             o_rx_en;
    logic [3:0]       o_rx_mode;
    logic             o_busy;
    logic             o_byte_strobe;
    logic             o_done;
    logic             o_error;
    logic [1:0]       o_err_code;
    logic [CNT_W-1:0] o_word_cnt;

    modport master (
        output i_start, i_abort, i_rx_mode_done, i_rx_pre, i_rx_error,
        input  o_rx_en, o_rx_mode, o_busy, o_byte_strobe, o_done, o_error,
               o_err_code, o_word_cnt
    );

    modport slave (
        input  i_start, i_abort, i_rx_mode_done, i_rx_pre, i_rx_error,
        output o_rx_en, o_rx_mode, o_busy, o_byte_strobe, o_done, o_error,
               o_err_code, o_word_cnt
    );
endinterface

// File: rtl/ddr_rx_watchdog.sv
// Loadable down-counter. Loaded on every sequencer state change, it counts
// down while the deserializer runs and flags expiry once it reaches zero.
// Only instantiated when RX_SEQ_TIMEOUT_EN is defined.
module ddr_rx_watchdog #(
    parameter int LOAD_W = 10
) (
    input  logic              i_sys_clk,
    input  logic              i_sys_rst,
    input  logic              i_load,
    input  logic              i_run,
    input  logic [LOAD_W-1:0] i_load_val,
    output logic              o_expire
);

    logic [LOAD_W-1:0] cnt_q;

    // Reload on state entry, otherwise count down to zero and stick there
    always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
        if (!i_sys_rst)                   cnt_q <= '0;
        else if (i_load)                  cnt_q <= i_load_val;
        else if (i_run && cnt_q != '0)    cnt_q <= cnt_q - 1'b1;
    end

    // Expiry depends only on the count, so it cannot loop back through i_load
    assign o_expire = i_run && (cnt_q == '0);

endmodule

// File: rtl/ddr_rx_sequencer.sv
// HDR-DDR receive sequencer: walks the deserializer through
// PRE->BYTE0->BYTE1->PAR per data word and PRE->TOKEN->CRC for the CRC word,
// counting data words and reporting done/error to the CCC controller.
// Optional per-mode timeout built only when RX_SEQ_TIMEOUT_EN is defined.
module ddr_rx_sequencer
    import ddr_pkg::*;
#(
    parameter int MAX_WORDS      = 16,
    parameter int CNT_W          = 5,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic               i_sys_clk,
    input  logic               i_sys_rst,
    ddr_rx_sequencer_if.slave  bus
);

    rx_seq_state_e    state_q, state_d;
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
    logic [1:0]       err_code_q, err_code_d;
    logic             timeout;

    // Next state, word count and error code; abort overrides everything
    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        err_code_d = err_code_q;
        case (state_q)
            S_IDLE: if (bus.i_start) begin
                state_d    = S_PRE;
                word_cnt_d = '0;
                err_code_d = ERR_PARITY;
            end
            S_PRE: if (bus.i_rx_mode_done) begin
                if (!bus.i_rx_pre) begin
                    state_d = S_TOKEN;
                end else if (word_cnt_q == CNT_W'(MAX_WORDS)) begin
                    state_d    = S_ERR;
                    err_code_d = ERR_OVERFLOW;
                end else begin
                    state_d = S_BYTE0;
                end
            end
            S_BYTE0: if (bus.i_rx_mode_done) state_d = S_BYTE1;
            S_BYTE1: if (bus.i_rx_mode_done) state_d = S_PAR;
            S_PAR: if (bus.i_rx_mode_done) begin
                if (bus.i_rx_error) begin
                    state_d    = S_ERR;
                    err_code_d = ERR_PARITY;
                end else begin
                    state_d    = S_PRE;
                    word_cnt_d = word_cnt_q + 1'b1;
                end
            end
            S_TOKEN, S_CRC: if (bus.i_rx_mode_done) begin
                if (bus.i_rx_error) begin
                    state_d    = S_ERR;
                    err_code_d = ERR_TOKEN_CRC;
                end else begin
                    state_d = (state_q == S_TOKEN) ? S_CRC : S_DONE;
                end
            end
            default: state_d = S_IDLE;   // DONE/ERR last one cycle
        endcase
        // A mode completing on the expiry cycle still counts as completed
        if (timeout && !bus.i_rx_mode_done) begin
            state_d    = S_ERR;
            err_code_d = ERR_TIMEOUT;
        end
        if (bus.i_abort) begin
            state_d    = S_IDLE;
            word_cnt_d = word_cnt_q;
            err_code_d = err_code_q;
        end
    end

    // State, word count and error code registers
    always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
        if (!i_sys_rst) begin
            state_q    <= S_IDLE;
            word_cnt_q <= '0;
            err_code_q <= ERR_PARITY;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            err_code_q <= err_code_d;
        end
    end

    // Registered output decode of the current state; abort silences it at once
    always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
        if (!i_sys_rst) begin
            bus.o_rx_en       <= 1'b0;
            bus.o_rx_mode     <= RX_IDLE;
            bus.o_byte_strobe <= 1'b0;
            bus.o_done        <= 1'b0;
            bus.o_error       <= 1'b0;
        end else begin
            bus.o_rx_en       <= !bus.i_abort && rx_active(state_q);
            bus.o_rx_mode     <= bus.i_abort ? RX_IDLE : rx_mode_of(state_q);
            bus.o_byte_strobe <= !bus.i_abort && bus.i_rx_mode_done &&
                                 (state_q == S_BYTE0 || state_q == S_BYTE1);
            bus.o_done        <= !bus.i_abort && (state_q == S_DONE);
            bus.o_error       <= !bus.i_abort && (state_q == S_ERR);
        end
    end

    assign bus.o_busy     = (state_q != S_IDLE);
    assign bus.o_err_code = err_code_q;
    assign bus.o_word_cnt = word_cnt_q;

`ifdef RX_SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    // Reloaded on every state change so each mode gets its own budget
    ddr_rx_watchdog #(.LOAD_W(WD_W)) u_watchdog (
        .i_sys_clk  (i_sys_clk),
        .i_sys_rst  (i_sys_rst),
        .i_load     (state_d != state_q),
        .i_run      (rx_active(state_q)),
        .i_load_val (WD_W'(TIMEOUT_CYCLES - 1)),
        .o_expire   (timeout)
    );
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_ddr_rx_sequencer.sv
// Directed bench for ddr_rx_sequencer (MAX_WORDS=2, TIMEOUT_CYCLES=8).
// The timeout scenario is compiled only with RX_SEQ_TIMEOUT_EN defined.
`timescale 1ns/1ps
module tb_ddr_rx_sequencer;

    localparam int MAXW  = 2;
    localparam int CNT_W = 5;
    localparam int TO    = 8;

    logic i_sys_clk = 1'b0;
    logic i_sys_rst = 1'b0;

    ddr_rx_sequencer_if #(.CNT_W(CNT_W)) bus();

    ddr_rx_sequencer #(.MAX_WORDS(MAXW), .CNT_W(CNT_W), .TIMEOUT_CYCLES(TO)) dut (
        .i_sys_clk (i_sys_clk),
        .i_sys_rst (i_sys_rst),
        .bus       (bus)
    );

    always #5 i_sys_clk = ~i_sys_clk;

    int n_chk = 0, n_err = 0;
    int n_strobe = 0, n_done = 0, n_error = 0;
    int s0, d0, e0;

    // Pulse tally, sampled mid-cycle
    always @(negedge i_sys_clk) begin
        if (bus.o_byte_strobe) n_strobe++;
        if (bus.o_done)        n_done++;
        if (bus.o_error)       n_error++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin @(posedge i_sys_clk); #1; end
    endtask

    task automatic start_phase();
        bus.i_start = 1'b1; cyc(1); bus.i_start = 1'b0;
    endtask

    task automatic rx_done(input logic pre, input logic err);
        bus.i_rx_mode_done = 1'b1; bus.i_rx_pre = pre; bus.i_rx_error = err;
        cyc(1);
        bus.i_rx_mode_done = 1'b0; bus.i_rx_pre = 1'b0; bus.i_rx_error = 1'b0;
    endtask

    task automatic step_chk(input logic pre, input logic err, input logic [3:0] mode, input string tag);
        rx_done(pre, err);
        cyc(1);
        chk(tag, 32'(bus.o_rx_mode), 32'(mode));
    endtask

    task automatic data_word();
        rx_done(1'b1, 1'b0); rx_done(1'b0, 1'b0); rx_done(1'b0, 1'b0); rx_done(1'b0, 1'b0);
    endtask

    initial begin
        bus.i_start = 1'b0; bus.i_abort = 1'b0; bus.i_rx_mode_done = 1'b0;
        bus.i_rx_pre = 1'b0; bus.i_rx_error = 1'b0;

        // Reset state
        cyc(3);
        chk("rst_en",   32'(bus.o_rx_en), 32'd0);
        chk("rst_mode", 32'(bus.o_rx_mode), 32'hf);
        chk("rst_busy", 32'(bus.o_busy), 32'd0);
        chk("rst_code", 32'(bus.o_err_code), 32'd0);
        chk("rst_cnt",  32'(bus.o_word_cnt), 32'd0);
        chk("rst_pulse", 32'(n_done + n_error + n_strobe), 32'd0);
        i_sys_rst = 1'b1;
        cyc(1);

        // Two data words then CRC word, clean
        s0 = n_strobe; d0 = n_done; e0 = n_error;
        start_phase();
        chk("t1_busy", 32'(bus.o_busy), 32'd1);
        cyc(1);
        chk("t1_pre_mode", 32'(bus.o_rx_mode), 32'h0);
        chk("t1_pre_en",   32'(bus.o_rx_en), 32'd1);
        for (int w = 0; w < 2; w++) begin
            step_chk(1'b1, 1'b0, 4'b0011, "t1_byte0");
            step_chk(1'b0, 1'b0, 4'b0011, "t1_byte1");
            step_chk(1'b0, 1'b0, 4'b0110, "t1_par");
            step_chk(1'b0, 1'b0, 4'b0000, "t1_pre");
            chk("t1_cnt", 32'(bus.o_word_cnt), 32'(w + 1));
        end
        step_chk(1'b0, 1'b0, 4'b0101, "t1_token");
        step_chk(1'b0, 1'b0, 4'b0111, "t1_crc");
        rx_done(1'b0, 1'b0);
        cyc(1);
        chk("t1_done_pulse", 32'(bus.o_done), 32'd1);
        cyc(1);
        chk("t1_done_low", 32'(bus.o_done), 32'd0);
        chk("t1_idle_busy", 32'(bus.o_busy), 32'd0);
        chk("t1_idle_en",   32'(bus.o_rx_en), 32'd0);
        chk("t1_idle_mode", 32'(bus.o_rx_mode), 32'hf);
        chk("t1_strobes", 32'(n_strobe - s0), 32'd4);
        chk("t1_dones",   32'(n_done - d0), 32'd1);
        chk("t1_errors",  32'(n_error - e0), 32'd0);
        chk("t1_cnt_end", 32'(bus.o_word_cnt), 32'd2);

        // Third data preamble with MAX_WORDS=2 -> overflow
        start_phase(); cyc(1);
        data_word(); data_word();
        rx_done(1'b1, 1'b0);
        cyc(1);
        chk("ovf_error", 32'(bus.o_error), 32'd1);
        chk("ovf_code",  32'(bus.o_err_code), 32'h2);
        chk("ovf_cnt",   32'(bus.o_word_cnt), 32'd2);
        cyc(1);

        // Parity error on the first word
        start_phase(); cyc(1);
        rx_done(1'b1, 1'b0); rx_done(1'b0, 1'b0); rx_done(1'b0, 1'b0);
        rx_done(1'b0, 1'b1);
        cyc(1);
        chk("par_error", 32'(bus.o_error), 32'd1);
        chk("par_en",    32'(bus.o_rx_en), 32'd0);
        chk("par_code",  32'(bus.o_err_code), 32'h0);
        chk("par_cnt",   32'(bus.o_word_cnt), 32'd0);
        cyc(1);
        chk("par_err_low", 32'(bus.o_error), 32'd0);

        // Token mismatch on CRC word
        start_phase(); cyc(1);
        rx_done(1'b0, 1'b0); rx_done(1'b0, 1'b1);
        cyc(1);
        chk("tok_error", 32'(bus.o_error), 32'd1);
        chk("tok_code",  32'(bus.o_err_code), 32'h1);
        cyc(1);

        // Abort during BYTE1 of the second word
        start_phase(); cyc(1);
        data_word();
        rx_done(1'b1, 1'b0); rx_done(1'b0, 1'b0);
        d0 = n_done; e0 = n_error;
        bus.i_abort = 1'b1; cyc(1); bus.i_abort = 1'b0;
        chk("abt_busy", 32'(bus.o_busy), 32'd0);
        chk("abt_en",   32'(bus.o_rx_en), 32'd0);
        cyc(2);
        chk("abt_nopulse", 32'(n_done - d0 + n_error - e0), 32'd0);
        chk("abt_cnt_held", 32'(bus.o_word_cnt), 32'd1);
        bus.i_start = 1'b1; bus.i_abort = 1'b1; cyc(1);
        bus.i_start = 1'b0; bus.i_abort = 1'b0;
        chk("abt_start_same", 32'(bus.o_busy), 32'd0);
        rx_done(1'b1, 1'b0);
        chk("idle_modedone", 32'(bus.o_busy), 32'd0);
        start_phase();
        chk("abt_restart_busy", 32'(bus.o_busy), 32'd1);
        chk("abt_restart_cnt",  32'(bus.o_word_cnt), 32'd0);
        cyc(1);
        chk("abt_restart_mode", 32'(bus.o_rx_mode), 32'h0);
        bus.i_abort = 1'b1; cyc(1); bus.i_abort = 1'b0;
        cyc(1);

        // Asynchronous reset mid-phase, then a bare CRC word
        start_phase(); cyc(1);
        data_word(); rx_done(1'b1, 1'b0);
        cyc(1);
        d0 = n_done; e0 = n_error;
        #1 i_sys_rst = 1'b0;
        #1;
        chk("arst_en",   32'(bus.o_rx_en), 32'd0);
        chk("arst_mode", 32'(bus.o_rx_mode), 32'hf);
        chk("arst_busy", 32'(bus.o_busy), 32'd0);
        chk("arst_cnt",  32'(bus.o_word_cnt), 32'd0);
        @(negedge i_sys_clk); i_sys_rst = 1'b1;
        cyc(1);
        start_phase();
        step_chk(1'b0, 1'b0, 4'b0101, "arst_token");
        step_chk(1'b0, 1'b0, 4'b0111, "arst_crc");
        rx_done(1'b0, 1'b0);
        cyc(2);
        chk("arst_done",  32'(n_done - d0), 32'd1);
        chk("arst_noerr", 32'(n_error - e0), 32'd0);
        chk("arst_cnt0",  32'(bus.o_word_cnt), 32'd0);

`ifdef RX_SEQ_TIMEOUT_EN
        // No mode-done in PRE -> timeout error
        start_phase();
        cyc(TO);
        chk("to_early", 32'(bus.o_error), 32'd0);
        cyc(1);
        chk("to_error", 32'(bus.o_error), 32'd1);
        chk("to_code",  32'(bus.o_err_code), 32'h3);
        cyc(1);
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
